// File: rtl/boot_copier.sv
// boot_copier: copies COPY_LEN boot ROM bytes into RAM at DEST_BASE, holding the CPU in reset until done.
// Define BOOT_COPIER_CHECKSUM_EN to build the running 8-bit checksum of copied bytes.
module boot_copier #(
  parameter int unsigned           ROM_ADDR_W = 11,
  parameter int unsigned           RAM_ADDR_W = 16,
  parameter int unsigned           COPY_LEN   = 2048,
  parameter logic [RAM_ADDR_W-1:0] DEST_BASE  = 16'hF800
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_we,
  input  logic                  ram_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_reset_n,
  output logic [7:0]            checksum
);

  typedef enum logic [1:0] {StAddr, StData, StWrite, StDone} state_e;

  localparam logic [ROM_ADDR_W-1:0] LastCnt = ROM_ADDR_W'(COPY_LEN - 1);

  state_e                  state_q, state_d;
  logic [ROM_ADDR_W-1:0]   cnt_q, cnt_d;
  logic [RAM_ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [7:0]              ram_wdata_q, ram_wdata_d;
  logic                    ram_we_q, ram_we_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    accept;
  logic                    rearm;

  assign accept = (state_q == StWrite) && ram_ready;
  assign rearm  = (state_q == StDone) && restart;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = ram_we_q;
    busy_d      = busy_q;
    done_d      = done_q;
    unique case (state_q)
      // The ROM captures rom_addr on this edge; its data shows up in StData.
      StAddr: state_d = StData;
      StData: begin
        ram_wdata_d = rom_data;
        ram_addr_d  = DEST_BASE + RAM_ADDR_W'(cnt_q);
        ram_we_d    = 1'b1;
        state_d     = StWrite;
      end
      StWrite: begin
        if (accept) begin
          ram_we_d = 1'b0;
          if (cnt_q == LastCnt) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + ROM_ADDR_W'(1);
            state_d = StAddr;
          end
        end
      end
      StDone: begin
        if (rearm) begin
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = StAddr;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAddr;
      cnt_q       <= '0;
      ram_addr_q  <= DEST_BASE;
      ram_wdata_q <= 8'h00;
      ram_we_q    <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef BOOT_COPIER_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (rearm) begin
      checksum_d = 8'h00;
    end else if (accept) begin
      checksum_d = checksum_q + ram_wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= 8'h00;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 8'h00;
`endif

  assign rom_addr    = cnt_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_we      = ram_we_q;
  assign busy        = busy_q;
  assign done        = done_q;
  // The CPU leaves reset exactly when the copy is complete.
  assign cpu_reset_n = done_q;

endmodule

// File: tb/tb_boot_copier.sv
// Bench for boot_copier: a default-parameter copier and a small wrapping copier checked every cycle
// against a timeline model, plus directed literal checks for backpressure, reset, restart and checksum.
module tb_boot_copier;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Main instance (defaults) signals.
  logic        restart_m, ready_m;
  logic [10:0] rom_addr_m;
  logic [7:0]  rom_data_m, ram_wdata_m, cks_m;
  logic [15:0] ram_addr_m;
  logic        ram_we_m, busy_m, done_m, cpu_rst_m;

  // Wrapping instance signals.
  logic        restart_w = 1'b0;
  logic        ready_w = 1'b1;
  logic [10:0] rom_addr_w;
  logic [7:0]  rom_data_w, ram_wdata_w, cks_w;
  logic [15:0] ram_addr_w;
  logic        ram_we_w, busy_w, done_w, cpu_rst_w;

  boot_copier u_main (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart_m),
    .rom_addr   (rom_addr_m),
    .rom_data   (rom_data_m),
    .ram_addr   (ram_addr_m),
    .ram_wdata  (ram_wdata_m),
    .ram_we     (ram_we_m),
    .ram_ready  (ready_m),
    .busy       (busy_m),
    .done       (done_m),
    .cpu_reset_n(cpu_rst_m),
    .checksum   (cks_m)
  );

  boot_copier #(
    .COPY_LEN (4),
    .DEST_BASE(16'hFFFE)
  ) u_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (restart_w),
    .rom_addr   (rom_addr_w),
    .rom_data   (rom_data_w),
    .ram_addr   (ram_addr_w),
    .ram_wdata  (ram_wdata_w),
    .ram_we     (ram_we_w),
    .ram_ready  (ready_w),
    .busy       (busy_w),
    .done       (done_w),
    .cpu_reset_n(cpu_rst_w),
    .checksum   (cks_w)
  );

  function automatic logic [7:0] rom_byte(input int d, input int a);
    logic [31:0] av;
    av = a;
    if (d == 0) return av[7:0];
    case (a)
      0:       return 8'h80;
      1:       return 8'h90;
      2:       return 8'h01;
      3:       return 8'h02;
      default: return 8'h00;
    endcase
  endfunction

  // ROMs with one cycle of registered-address latency.
  always @(posedge clk) begin
    rom_data_m <= rom_byte(0, int'(rom_addr_m));
    rom_data_w <= rom_byte(1, int'(rom_addr_w));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: edges counted from reset release (or the restart edge, as edge 0).
  int          n_len[2] = '{2048, 4};
  logic [15:0] base[2] = '{16'hF800, 16'hFFFE};
  int          e[2], k[2], nstart[2], done_at[2];
  bit          dn[2], dn_nx[2], rs_pend[2];
  logic [7:0]  cks[2];
  logic [15:0] wrap_addrs[$];

  task automatic model_init(input int d);
    e[d] = 0; k[d] = 0; nstart[d] = 2; done_at[d] = -1;
    dn[d] = 0; dn_nx[d] = 0; rs_pend[d] = 0; cks[d] = 8'h00;
  endtask

  task automatic model_step(input int d, input logic rstn, input logic rstrt, input logic rdy,
                            input logic [10:0] ra, input logic [15:0] addr, input logic [7:0] wd,
                            input logic we, input logic bsy, input logic dne, input logic cpurn,
                            input logic [7:0] cs);
    bit          exp_we;
    logic [7:0]  exp_cs;
    logic [15:0] exp_addr;
    if (!rstn) begin
      model_init(d);
      chk($sformatf("dut%0d reset rom_addr", d), ra, 0);
      chk($sformatf("dut%0d reset ram_addr", d), addr, base[d]);
      chk($sformatf("dut%0d reset wdata", d), wd, 0);
      chk($sformatf("dut%0d reset we", d), we, 0);
      chk($sformatf("dut%0d reset busy", d), bsy, 1);
      chk($sformatf("dut%0d reset done", d), dne, 0);
      chk($sformatf("dut%0d reset cpu_reset_n", d), cpurn, 0);
      chk($sformatf("dut%0d reset checksum", d), cs, 0);
      return;
    end
    e[d]++;
    if (dn_nx[d]) begin dn[d] = 1; dn_nx[d] = 0; end
    if (rs_pend[d]) begin
      model_init(d);
    end
    if (dn[d] && done_at[d] < 0) done_at[d] = e[d];
`ifdef BOOT_COPIER_CHECKSUM_EN
    exp_cs = cks[d];
`else
    exp_cs = 8'h00;
`endif
    exp_we = !dn[d] && e[d] >= nstart[d];
    chk($sformatf("dut%0d we", d), we, exp_we);
    chk($sformatf("dut%0d busy", d), bsy, !dn[d]);
    chk($sformatf("dut%0d done", d), dne, dn[d]);
    chk($sformatf("dut%0d cpu_reset_n", d), cpurn, dn[d]);
    chk($sformatf("dut%0d rom_addr", d), ra, k[d]);
    chk($sformatf("dut%0d checksum", d), cs, exp_cs);
    exp_addr = base[d] + 16'(k[d]);
    if (exp_we) begin
      chk($sformatf("dut%0d ram_addr", d), addr, exp_addr);
      chk($sformatf("dut%0d wdata", d), wd, rom_byte(d, k[d]));
    end
    // Look ahead to the coming edge using the ready value it will see.
    if (exp_we && rdy) begin
      cks[d] = cks[d] + rom_byte(d, k[d]);
      if (k[d] == n_len[d] - 1) dn_nx[d] = 1;
      else begin k[d]++; nstart[d] = e[d] + 3; end
    end
    rs_pend[d] = dn[d] && rstrt;
  endtask

  always @(negedge clk) begin
    model_step(0, rst_n, restart_m, ready_m, rom_addr_m, ram_addr_m, ram_wdata_m, ram_we_m,
               busy_m, done_m, cpu_rst_m, cks_m);
    model_step(1, rst_n, restart_w, ready_w, rom_addr_w, ram_addr_w, ram_wdata_w, ram_we_w,
               busy_w, done_w, cpu_rst_w, cks_w);
    if (rst_n && ram_we_w && ready_w) wrap_addrs.push_back(ram_addr_w);
  end

  task automatic wait_byte(input int idx, input int max_cyc, output bit ok);
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (ram_we_m && ram_addr_m == 16'(32'hF800 + idx)) begin ok = 1; break; end
    end
    if (!ok) chk($sformatf("timeout waiting byte %0d", idx), 0, 1);
  endtask

  task automatic wait_done(input int max_cyc);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      if (done_m) begin ok = 1; break; end
    end
    if (!ok) chk("timeout waiting done", 0, 1);
    @(negedge clk); #1;
  endtask

  task automatic pulse_restart();
    @(posedge clk); #1 restart_m = 1'b1;
    @(posedge clk); #1 restart_m = 1'b0;
  endtask

  initial begin
    bit ok;
    ready_m = 1'b1;
    restart_m = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;

    // Backpressure on byte 3: outputs hold for 5 stalled edges.
    wait_byte(3, 50, ok);
    if (ok) begin
      ready_m = 1'b0;
      repeat (5) begin
        @(posedge clk); #1;
        chk("bp we", ram_we_m, 1);
        chk("bp addr", ram_addr_m, 16'hF803);
        chk("bp wdata", ram_wdata_m, 8'h03);
      end
      ready_m = 1'b1;
    end

    // Restart while busy must be ignored.
    wait_byte(50, 400, ok);
    pulse_restart();
    chk("restart while busy", busy_m, 1);

    wait_done(7000);
    chk("first done edge", done_at[0], 6149);
    chk("wrap done edge", done_at[1], 12);
    chk("wrap write count", wrap_addrs.size(), 4);
    if (wrap_addrs.size() >= 4) begin
      chk("wrap addr0", wrap_addrs[0], 16'hFFFE);
      chk("wrap addr1", wrap_addrs[1], 16'hFFFF);
      chk("wrap addr2", wrap_addrs[2], 16'h0000);
      chk("wrap addr3", wrap_addrs[3], 16'h0001);
    end
`ifdef BOOT_COPIER_CHECKSUM_EN
    chk("wrap checksum", cks_w, 8'h13);
`else
    chk("wrap checksum", cks_w, 8'h00);
`endif
    chk("main checksum", cks_m, 8'h00);
    chk("cpu released", cpu_rst_m, 1);

    // Restart in DONE: CPU back in reset on the next edge, full copy again.
    pulse_restart();
    chk("restart busy", busy_m, 1);
    chk("restart done", done_m, 0);
    chk("restart cpu_reset_n", cpu_rst_m, 0);
    wait_done(7000);
    chk("second done edge", done_at[0], 6144);

    // Reset in the middle of byte 100.
    pulse_restart();
    wait_byte(100, 500, ok);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst rom_addr", rom_addr_m, 0);
    chk("async rst ram_addr", ram_addr_m, 16'hF800);
    chk("async rst wdata", ram_wdata_m, 0);
    chk("async rst we", ram_we_m, 0);
    chk("async rst busy", busy_m, 1);
    chk("async rst done", done_m, 0);
    chk("async rst cpu_reset_n", cpu_rst_m, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("byte0 rewrite we", ram_we_m, 1);
    chk("byte0 rewrite addr", ram_addr_m, 16'hF800);
    chk("byte0 rewrite data", ram_wdata_m, 8'h00);
    wait_done(7000);
    chk("post-reset done edge", done_at[0], 6144);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_copier.md
# boot_copier

Sequencer that copies the boot ROM image into main RAM at power-up and holds the CPU in reset until the copy completes. It sits between the boot ROM and the RAM write port. It drives the ROM address and consumes ROM read data, which has one cycle of registered-address latency. It writes each byte into RAM through a ready/valid write handshake, then releases the CPU.

## Interface
Parameters:
- `ROM_ADDR_W`, default 11: ROM address width; ROM holds 2^ROM_ADDR_W bytes.
- `RAM_ADDR_W`, default 16: RAM address width.
- `COPY_LEN`, default 2048: bytes to copy; legal range 1..2^ROM_ADDR_W.
- `DEST_BASE`, default 16'hF800: RAM address of the first byte.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst_n` in 1: asynchronous, active-low reset.
- `restart` in 1: one-cycle pulse; restarts the copy from DONE.
- `rom_addr` out ROM_ADDR_W: ROM address; the ROM registers it on `clk`.
- `rom_data` in 8: ROM data; valid in the cycle after `rom_addr` is captured.
- `ram_addr` out RAM_ADDR_W: RAM write address.
- `ram_wdata` out 8: RAM write data.
- `ram_we` out 1: write request (valid).
- `ram_ready` in 1: RAM accepts the write in any cycle where `ram_we && ram_ready`.
- `busy` out 1: a copy is in progress.
- `done` out 1: the copy has completed.
- `cpu_reset_n` out 1: CPU reset, low while not done.
- `checksum` out 8: running sum of copied bytes (see Configuration).

## Operation
- FSM states: ADDR, DATA, WRITE, DONE. All outputs are registered.
- Byte counter `cnt` is ROM_ADDR_W bits wide. `rom_addr` equals `cnt` at all times.
- ADDR: wait one cycle while the ROM captures `rom_addr`; go to DATA.
- DATA: `rom_data` is valid. On the edge: `ram_wdata <= rom_data`, `ram_addr <= DEST_BASE + cnt`, `ram_we <= 1`; go to WRITE.
- Address arithmetic: `DEST_BASE + cnt` is truncated to RAM_ADDR_W bits and wraps modulo 2^RAM_ADDR_W.
- WRITE: hold `ram_we`, `ram_addr` and `ram_wdata` stable while `ram_ready` is 0.
- WRITE, on acceptance (`ram_ready` = 1): `ram_we <= 0`.
  - If `cnt == COPY_LEN-1`: go to DONE; `busy <= 0`, `done <= 1`, `cpu_reset_n <= 1`.
  - Else: `cnt <= cnt + 1` and go to ADDR.
- DONE: outputs are static and `ram_we` = 0.
  - A `restart` pulse sets `cnt <= 0`, `busy <= 1`, `done <= 0`, `cpu_reset_n <= 0`, then goes to ADDR.
- `restart` is ignored in every state except DONE.
- Reset (async, at any time, including mid-copy): state ADDR, `cnt` = 0. Output reset values:
  - `rom_addr` = 0, `ram_addr` = DEST_BASE, `ram_wdata` = 0, `ram_we` = 0
  - `busy` = 1, `done` = 0, `cpu_reset_n` = 0, `checksum` = 0
  - The copy restarts from byte 0 after reset is released.
- Exactly one RAM write is issued per byte. The same address is never issued twice within one copy.

## Timing
- Edge numbering: edge 1 is the first rising `clk` after `rst_n` rises.
- With `ram_ready` held at 1:
  - `ram_we` for byte i is high from edge 3i+2 to edge 3i+3.
  - `done` and `cpu_reset_n` rise at edge 3·COPY_LEN (6144 for the defaults).
- Each cycle of `ram_ready` = 0 in WRITE adds one cycle to that byte and to every later event.
- `busy` and `done` are never high together. `cpu_reset_n` always equals `done`.
- A `restart` pulse in DONE: `busy` rises on the next edge, and byte 0 is written at edge +2 (relative to that edge).

## Configuration
- `BOOT_COPIER_CHECKSUM_EN` defined:
  - `checksum` is an 8-bit modulo-256 sum of every accepted `ram_wdata`, updated on each acceptance edge.
  - It is cleared on reset and on `restart`.
  - It holds its final value in DONE.
- Not defined: `checksum` is tied to 0 and no adder is built.

## Test plan
- Default parameters, ROM byte k = k[7:0], `ram_ready` = 1 → 2048 writes:
  - addresses 0xF800..0xFFFF with data k[7:0]
  - `done` and `cpu_reset_n` rise at edge 6144
- Backpressure: `ram_ready` = 0 for 5 cycles during byte 3 → `ram_we`, `ram_addr` (0xF803) and `ram_wdata` stay stable; completion slips by exactly 5 cycles.
- Wrap: DEST_BASE = 16'hFFFE, COPY_LEN = 4 → write addresses FFFE, FFFF, 0000, 0001 in that order; `done` at edge 12.
- Reset mid-copy: assert `rst_n` = 0 during byte 100 → all outputs take their reset values immediately; after release, byte 0 is rewritten at edge 2.
- Restart: `restart` pulsed while `busy` → no effect. Pulsed in DONE → `cpu_reset_n` drops on the next edge and a full second copy completes.
- Built with `BOOT_COPIER_CHECKSUM_EN`, COPY_LEN = 4, ROM data 0x80, 0x90, 0x01, 0x02 → `checksum` = 0x13 in DONE. Built without the macro → `checksum` = 0 throughout.
